// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   MIPS general-purpose register file for the single-cycle datapath.
//   Two independent combinational read ports (rs -> ALU operand a, rt -> ALUSrc
//   mux / store data) and one synchronous write port fed from the MemtoReg mux.
//   Register $0 is hard-wired to zero: writes to it are dropped and reads of
//   address 0 always return 0.
//
// Parameters
//   DATA_W  width of each register and of all data ports
//   ADDR_W  register address width; depth = 2**ADDR_W
//   BYPASS  1: a read of the register being written this cycle returns
//              write_data; 0: it returns the stored (old) value
//
// Ports
//   clk         in   1       clock; writes occur on the rising edge
//   rst_n       in   1       asynchronous active-low reset, clears every register
//   RegWrite    in   1       write enable from main control
//   read_reg1   in   ADDR_W  read address, port 1 (rs)
//   read_reg2   in   ADDR_W  read address, port 2 (rt)
//   write_reg   in   ADDR_W  write address (RegDst mux output)
//   write_data  in   DATA_W  write data (MemtoReg mux output)
//   read_data1  out  DATA_W  contents of read_reg1
//   read_data2  out  DATA_W  contents of read_reg2
// -----------------------------------------------------------------------------
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic            BYPASS_EN = (BYPASS != 0);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

    // Entry 0 exists only so that dynamic indexing stays in range; it is
    // cleared by reset, never written, and masked on both read ports.
    logic [DATA_W-1:0] regs_r [DEPTH];

    logic wr_en_s;
    logic hit1_s;
    logic hit2_s;

    // Qualified write enable. RegWrite is compared against 1'b1 so that an
    // unknown enable is treated as "no write" and cannot disturb any register.
    always_comb begin
        wr_en_s = 1'b0;
        if ((RegWrite === 1'b1) && (write_reg != ZERO_ADDR)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Register storage: asynchronous clear, single write per rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= ZERO_DATA;
            end
        end else if (wr_en_s) begin
            regs_r[write_reg] <= write_data;
        end
    end

    // Same-cycle forwarding detection; suppressed while reset is held so that
    // both ports read zero for the whole reset window.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        if (BYPASS_EN && rst_n && wr_en_s) begin
            hit1_s = (read_reg1 == write_reg);
            hit2_s = (read_reg2 == write_reg);
        end else begin
            hit1_s = 1'b0;
            hit2_s = 1'b0;
        end
    end

    // Read port 1: address 0 wins over bypass, bypass wins over storage.
    always_comb begin
        read_data1 = ZERO_DATA;
        if (read_reg1 == ZERO_ADDR) begin
            read_data1 = ZERO_DATA;
        end else if (hit1_s) begin
            read_data1 = write_data;
        end else begin
            read_data1 = regs_r[read_reg1];
        end
    end

    // Read port 2: same priority as port 1, evaluated independently.
    always_comb begin
        read_data2 = ZERO_DATA;
        if (read_reg2 == ZERO_ADDR) begin
            read_data2 = ZERO_DATA;
        end else if (hit2_s) begin
            read_data2 = write_data;
        end else begin
            read_data2 = regs_r[read_reg2];
        end
    end

endmodule
